// File: rtl/buscaminas_board_ctrl.sv
// buscaminas_board_ctrl: 8x8 minesweeper board datapath driven by an external game FSM.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   btn_up/down/left/right       cursor move buttons (level)
//   btn_sel/flag/start           reveal, flag and start buttons (level)
//   bomb_map[63:0]               bomb layout, cell index = y*8+x, latched at board init
//   enable_matriz .. win         one-hot state strobes from the game FSM
//   I, W, L, C, M, F, B          condition flags returned to the game FSM
//   cursor_x, cursor_y           cursor column / row
//   revealed, flagged            per-cell status
//   adj_count                    bombs around the cursor cell
//
// Configuration: define BUSCAMINAS_ADJ_COUNT_EN to build the registered neighbour bomb counter;
// otherwise adj_count is tied to zero.

module buscaminas_board_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  input  logic        btn_flag,
  input  logic        btn_start,
  input  logic [63:0] bomb_map,
  input  logic        enable_matriz,
  input  logic        movement,
  input  logic        click_casillas,
  input  logic        mmm_put_flag,
  input  logic        put_flag,
  input  logic        mmm_bomb,
  input  logic        game_over,
  input  logic        win,
  output logic        I,
  output logic        W,
  output logic        L,
  output logic        C,
  output logic        M,
  output logic        F,
  output logic        B,
  output logic [2:0]  cursor_x,
  output logic [2:0]  cursor_y,
  output logic [63:0] revealed,
  output logic [63:0] flagged,
  output logic [3:0]  adj_count
);

  // Button bit order: {start, flag, sel, right, left, down, up}
  logic [6:0]  btn_q, btn_prev_q, btn_ev;
  logic [3:0]  pend_q, pend_d;          // one-hot {right, left, down, up}
  logic        act_pend_q, act_pend_d;
  logic        act_flag_q, act_flag_d;
  logic [63:0] bomb_q, bomb_d;
  logic [63:0] revealed_q, revealed_d;
  logic [63:0] flagged_q, flagged_d;
  logic [6:0]  rev_cnt_q, rev_cnt_d;
  logic [6:0]  bomb_total_q, bomb_total_d;
  logic [2:0]  cursor_x_q, cursor_x_d;
  logic [2:0]  cursor_y_q, cursor_y_d;
  logic [5:0]  cur;
  logic        idle, ended, init;

  assign btn_ev = btn_q & ~btn_prev_q;
  assign cur    = {cursor_y_q, cursor_x_q};
  assign idle   = ~(enable_matriz | movement | click_casillas | mmm_put_flag | put_flag |
                    mmm_bomb | game_over | win);
  assign ended  = game_over | win;
  assign init   = btn_ev[6] & idle;

  always_comb begin
    pend_d       = pend_q;
    act_pend_d   = act_pend_q;
    act_flag_d   = act_flag_q;
    bomb_d       = bomb_q;
    revealed_d   = revealed_q;
    flagged_d    = flagged_q;
    rev_cnt_d    = rev_cnt_q;
    bomb_total_d = bomb_total_q;
    cursor_x_d   = cursor_x_q;
    cursor_y_d   = cursor_y_q;
    if (init) begin
      bomb_d       = bomb_map;
      revealed_d   = '0;
      flagged_d    = '0;
      rev_cnt_d    = '0;
      bomb_total_d = 7'($countones(bomb_map));
      cursor_x_d   = '0;
      cursor_y_d   = '0;
      pend_d       = '0;
      act_pend_d   = 1'b0;
      act_flag_d   = 1'b0;
    end else begin
      if (movement) begin
        if (pend_q[0] && cursor_y_q != 3'd0) cursor_y_d = cursor_y_q - 3'd1;
        if (pend_q[1] && cursor_y_q != 3'd7) cursor_y_d = cursor_y_q + 3'd1;
        if (pend_q[2] && cursor_x_q != 3'd0) cursor_x_d = cursor_x_q - 3'd1;
        if (pend_q[3] && cursor_x_q != 3'd7) cursor_x_d = cursor_x_q + 3'd1;
        pend_d = '0;
      end
      if (!ended) begin
        // A new direction event replaces whatever move is pending.
        if      (btn_ev[0]) pend_d = 4'b0001;
        else if (btn_ev[1]) pend_d = 4'b0010;
        else if (btn_ev[2]) pend_d = 4'b0100;
        else if (btn_ev[3]) pend_d = 4'b1000;
        if ((btn_ev[4] | btn_ev[5]) && !act_pend_q) begin
          act_pend_d = 1'b1;
          act_flag_d = ~btn_ev[4];
        end
      end
      // Strobe effects are applied after button events so the FSM always has the last word.
      if (mmm_put_flag && revealed_q[cur]) act_flag_d = 1'b0;
      if (put_flag) begin
        flagged_d[cur] = ~flagged_q[cur];
        act_pend_d     = 1'b0;
      end
      if (mmm_bomb) begin
        if (!flagged_q[cur] && !revealed_q[cur]) begin
          revealed_d[cur] = 1'b1;
          rev_cnt_d       = rev_cnt_q + 7'd1;
        end
        act_pend_d = 1'b0;
        act_flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q        <= '0;
      btn_prev_q   <= '0;
      pend_q       <= '0;
      act_pend_q   <= 1'b0;
      act_flag_q   <= 1'b0;
      bomb_q       <= '0;
      revealed_q   <= '0;
      flagged_q    <= '0;
      rev_cnt_q    <= '0;
      bomb_total_q <= '0;
      cursor_x_q   <= '0;
      cursor_y_q   <= '0;
    end else begin
      btn_q        <= {btn_start, btn_flag, btn_sel, btn_right, btn_left, btn_down, btn_up};
      btn_prev_q   <= btn_q;
      pend_q       <= pend_d;
      act_pend_q   <= act_pend_d;
      act_flag_q   <= act_flag_d;
      bomb_q       <= bomb_d;
      revealed_q   <= revealed_d;
      flagged_q    <= flagged_d;
      rev_cnt_q    <= rev_cnt_d;
      bomb_total_q <= bomb_total_d;
      cursor_x_q   <= cursor_x_d;
      cursor_y_q   <= cursor_y_d;
    end
  end

  assign I        = btn_ev[6];
  assign L        = btn_ev[6];
  assign M        = act_pend_q;
  assign C        = act_flag_q;
  assign F        = ~revealed_q[cur];
  assign B        = bomb_q[cur] & ~flagged_q[cur];
  // 64 - bomb_total fits in 7 bits, so an all-bomb board reads W=1 at rev_cnt=0.
  assign W        = (rev_cnt_q == (7'd64 - bomb_total_q));
  assign cursor_x = cursor_x_q;
  assign cursor_y = cursor_y_q;
  assign revealed = revealed_q;
  assign flagged  = flagged_q;

`ifdef BUSCAMINAS_ADJ_COUNT_EN
  logic [3:0] adj_q, adj_d;

  always_comb begin
    adj_d = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (!(dx == 0 && dy == 0)) begin
          int nx, ny;
          nx = int'(cursor_x_q) + dx;
          ny = int'(cursor_y_q) + dy;
          if (nx >= 0 && nx <= 7 && ny >= 0 && ny <= 7) begin
            if (bomb_q[6'(ny * 8 + nx)]) adj_d = adj_d + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) adj_q <= '0;
    else     adj_q <= adj_d;
  end

  assign adj_count = adj_q;
`else
  assign adj_count = 4'd0;
`endif

endmodule

// File: tb/tb_buscaminas_board_ctrl.sv
// Self-checking bench for buscaminas_board_ctrl: directed scenarios followed by random button /
// strobe traffic, all compared every cycle against a behavioural board model.

module tb_buscaminas_board_ctrl;

  logic        clk, rst;
  logic [6:0]  btn;   // {start, flag, sel, right, left, down, up}
  logic [7:0]  st;    // {win, game_over, mmm_bomb, put_flag, mmm_put_flag, click, movement, en}
  logic [63:0] bomb_map;
  logic        I, W, L, C, M, F, B;
  logic [2:0]  cursor_x, cursor_y;
  logic [63:0] revealed, flagged;
  logic [3:0]  adj_count;

  int n_checks = 0;
  int n_fail   = 0;

  buscaminas_board_ctrl dut (
    .clk(clk), .rst(rst),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
    .btn_sel(btn[4]), .btn_flag(btn[5]), .btn_start(btn[6]),
    .bomb_map(bomb_map),
    .enable_matriz(st[0]), .movement(st[1]), .click_casillas(st[2]), .mmm_put_flag(st[3]),
    .put_flag(st[4]), .mmm_bomb(st[5]), .game_over(st[6]), .win(st[7]),
    .I(I), .W(W), .L(L), .C(C), .M(M), .F(F), .B(B),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .revealed(revealed), .flagged(flagged), .adj_count(adj_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model
  bit [6:0]  m_b1, m_b2;     // button level last cycle / two cycles ago
  int        m_pend;         // 0 none, 1 up, 2 down, 3 left, 4 right
  int        m_cx, m_cy;
  bit        m_ap, m_af;
  bit [63:0] m_bomb, m_rev, m_flg;
  int        m_cnt, m_tot, m_adj;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int nbrs(input int x, input int y, input bit [63:0] b);
    int n = 0;
    for (int yy = y - 1; yy <= y + 1; yy++)
      for (int xx = x - 1; xx <= x + 1; xx++)
        if (!(xx == x && yy == y) && xx >= 0 && xx < 8 && yy >= 0 && yy < 8 && b[yy*8+xx])
          n++;
    return n;
  endfunction

  task automatic model_reset();
    m_b1 = '0; m_b2 = '0; m_pend = 0; m_cx = 0; m_cy = 0; m_ap = 0; m_af = 0;
    m_bomb = '0; m_rev = '0; m_flg = '0; m_cnt = 0; m_tot = 0; m_adj = 0;
  endtask

  // Advances the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit [6:0] ev;
    int cur, nadj;
    ev   = m_b1 & ~m_b2;
    cur  = m_cy * 8 + m_cx;
    nadj = nbrs(m_cx, m_cy, m_bomb);
    m_b2 = m_b1;
    m_b1 = btn;
    if (ev[6] && st == 8'd0) begin
      m_bomb = bomb_map; m_rev = '0; m_flg = '0; m_cnt = 0; m_tot = $countones(bomb_map);
      m_cx = 0; m_cy = 0; m_pend = 0; m_ap = 0; m_af = 0;
    end else begin
      if (st[1]) begin
        case (m_pend)
          1: m_cy = (m_cy > 0) ? m_cy - 1 : 0;
          2: m_cy = (m_cy < 7) ? m_cy + 1 : 7;
          3: m_cx = (m_cx > 0) ? m_cx - 1 : 0;
          4: m_cx = (m_cx < 7) ? m_cx + 1 : 7;
          default: ;
        endcase
        m_pend = 0;
      end
      if (!(st[6] || st[7])) begin
        for (int d = 3; d >= 0; d--) if (ev[d]) m_pend = d + 1;
        if ((ev[4] || ev[5]) && !m_ap) begin
          m_ap = 1;
          m_af = !ev[4];
        end
      end
      if (st[3] && m_rev[cur]) m_af = 0;
      if (st[4]) begin
        m_flg[cur] = !m_flg[cur];
        m_ap = 0;
      end
      if (st[5]) begin
        if (!m_flg[cur] && !m_rev[cur]) begin
          m_rev[cur] = 1;
          m_cnt++;
        end
        m_ap = 0;
        m_af = 0;
      end
    end
    m_adj = nadj;
  endtask

  task automatic compare_all();
    int cur;
    bit start_ev;
    cur = m_cy * 8 + m_cx;
    start_ev = m_b1[6] & ~m_b2[6];
    check("I", 64'(I), 64'(start_ev));
    check("L", 64'(L), 64'(start_ev));
    check("M", 64'(M), 64'(m_ap));
    check("C", 64'(C), 64'(m_af));
    check("F", 64'(F), 64'(!m_rev[cur]));
    check("B", 64'(B), 64'(m_bomb[cur] & !m_flg[cur]));
    check("W", 64'(W), 64'(m_cnt == 64 - m_tot));
    check("cursor_x", 64'(cursor_x), 64'(m_cx));
    check("cursor_y", 64'(cursor_y), 64'(m_cy));
    check("revealed", revealed, m_rev);
    check("flagged", flagged, m_flg);
`ifdef BUSCAMINAS_ADJ_COUNT_EN
    check("adj_count", 64'(adj_count), 64'(m_adj));
`else
    check("adj_count", 64'(adj_count), 64'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic press(input int k);
    btn[k] = 1'b1; tick();
    btn[k] = 1'b0; tick();
  endtask

  task automatic strobe(input int s);
    st[s] = 1'b1; tick();
    st[s] = 1'b0;
  endtask

  // Asynchronous reset asserted between edges, then released between edges.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    btn = '0; st = '0; bomb_map = '0; rst = 1'b0;
    model_reset();
    #2;
    do_reset();
    check("rst_F", 64'(F), 64'd1);
    check("rst_W", 64'(W), 64'd0);
    check("rst_M", 64'(M), 64'd0);

    // Start, move right
    bomb_map = 64'h1;
    btn[6] = 1'b1; tick();
    check("start_I_high", 64'(I), 64'd1);
    btn[6] = 1'b0; tick();
    check("start_I_low", 64'(I), 64'd0);
    press(3); strobe(1);
    check("right_x", 64'(cursor_x), 64'd1);
    check("right_y", 64'(cursor_y), 64'd0);
    check("right_F", 64'(F), 64'd1);
    check("right_B", 64'(B), 64'd0);

    // Saturation at both corners
    press(2); strobe(1);
    press(0); strobe(1);
    check("sat_up_y", 64'(cursor_y), 64'd0);
    check("sat_left_x", 64'(cursor_x), 64'd0);
    for (int i = 0; i < 7; i++) begin
      press(3); strobe(1);
      press(1); strobe(1);
    end
    press(1); strobe(1);
    press(3); strobe(1);
    check("sat_down_y", 64'(cursor_y), 64'd7);
    check("sat_right_x", 64'(cursor_x), 64'd7);

    // Reveal bomb at (0,0)
    press(6);
    press(4);
    check("sel_M", 64'(M), 64'd1);
    check("sel_C", 64'(C), 64'd0);
    check("sel_B", 64'(B), 64'd1);
    strobe(5);
    check("bomb_rev0", 64'(revealed[0]), 64'd1);

    // Flag toggle on cell 1
    press(3); strobe(1);
    for (int rep = 0; rep < 2; rep++) begin
      press(5);
      strobe(3);
      check("flag_F", 64'(F), 64'd1);
      check("flag_C", 64'(C), 64'd1);
      strobe(4);
      check("flag_cell1", 64'(flagged[1]), (rep == 0) ? 64'd1 : 64'd0);
      check("flag_M", 64'(M), 64'd0);
    end

    // Nearly full board: revealing one cell wins
    bomb_map = ~64'h1;
    press(6);
    press(3); strobe(1);
    press(4); strobe(5);
    check("win_W", 64'(W), 64'd1);
    press(2); strobe(1);
    tick();
`ifdef BUSCAMINAS_ADJ_COUNT_EN
    check("adj_corner", 64'(adj_count), 64'd3);
`endif

    // Reset with a pending reveal and its strobe present
    bomb_map = 64'h0;
    press(6);
    press(4);
    st[5] = 1'b1;
    do_reset();
    st[5] = 1'b0;
    check("abort_rev", revealed, 64'd0);
    check("abort_M", 64'(M), 64'd0);
    check("abort_x", 64'(cursor_x), 64'd0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      int r;
      for (int k = 0; k < 7; k++)
        if ($urandom_range(0, 3) == 0) btn[k] = ~btn[k];
      if ($urandom_range(0, 4) == 0) btn[6] = 1'b0;
      case ($urandom_range(0, 3))
        0: bomb_map = {$urandom() & $urandom(), $urandom() & $urandom()};
        1: bomb_map = ~({$urandom() & $urandom(), $urandom() & $urandom()} & 64'hFFFF_FFFF_FFFF);
        default: ;
      endcase
      r = $urandom_range(0, 15);
      st = '0;
      if (r < 6) st[r] = 1'b1;
      else if (r == 6 && $urandom_range(0, 3) == 0) st[6] = 1'b1;
      else if (r == 7 && $urandom_range(0, 3) == 0) st[7] = 1'b1;
      if ($urandom_range(0, 599) == 0) do_reset();
      else tick();
    end
    st = '0; btn = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buscaminas_board_ctrl.md
BUSCAMINAS_BOARD_CTRL -- requirements
Module: buscaminas_board_ctrl

Interface
REQ-001 SHALL have no parameters; the board is fixed at 8x8, cell index = y*8+x.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 btn_up, btn_down, btn_left, btn_right  in  1 each  cursor move buttons, level, synchronous to clk.
REQ-005 btn_sel, btn_flag, btn_start  in  1 each  reveal, flag and start buttons, level.
REQ-006 bomb_map  in  64  bomb layout, bit i = bomb in cell i; sampled only at board init.
REQ-007 enable_matriz, movement, click_casillas, mmm_put_flag, put_flag, mmm_bomb, game_over, win  in  1 each  one-hot state strobes from the game FSM.
REQ-008 I, W, L, C, M, F, B  out  1 each  condition inputs returned to the game FSM.
REQ-009 cursor_x, cursor_y  out  3 each  cursor column and row.
REQ-010 revealed, flagged  out  64 each  per-cell board status.
REQ-011 adj_count  out  4  bombs among the 8 neighbours of the cursor cell.

Function
REQ-012 Each button SHALL be registered; an event SHALL be a 1-cycle pulse when the registered value is high and was low the previous cycle.
REQ-013 idle = all eight FSM strobes low; I = start event; L = start event.
REQ-014 A start event while idle SHALL init the board: latch bomb_map, clear revealed/flagged, set cursor to (0,0), clear pending state, load bomb_total = popcount(bomb_map), and clear rev_cnt.
REQ-015 Direction events SHALL be stored in a 4-bit pending-move register. The last event wins, and simultaneous directions SHALL be resolved by priority up>down>left>right.
REQ-016 In a movement cycle, the cursor SHALL apply the pending move and then clear it. Moves SHALL saturate at 0 and 7 with no wrap. up = y-1, left = x-1.
REQ-017 A sel or flag event SHALL set act_pend and set act_flag (1 = flag, 0 = reveal) only when act_pend=0. Later events are dropped. sel SHALL have priority over a simultaneous flag.
REQ-018 M = act_pend; C = act_flag; F = ~revealed[cur]; B = bomb[cur] & ~flagged[cur]. All are combinational from registers.
REQ-019 In an mmm_put_flag cycle with F=0, act_flag SHALL clear so that the FSM leaves via the bomb-check path.
REQ-020 In a put_flag cycle, flagged[cur] SHALL toggle and act_pend SHALL clear.
REQ-021 In an mmm_bomb cycle, if ~flagged[cur] and ~revealed[cur], revealed[cur] SHALL set and rev_cnt SHALL increment (7-bit). act_pend and act_flag SHALL clear. A flagged cell is unchanged.
REQ-022 W SHALL be 1 when rev_cnt == 64 - bomb_total, with rev_cnt compared at 7 bits. A board with 64 bombs therefore reads W=1 immediately.
REQ-023 During game_over or win, all button events except start SHALL be ignored, and the board SHALL not be re-initialised.
REQ-024 A revealed bomb cell SHALL count in rev_cnt; W is irrelevant once game_over is active.

Reset
REQ-025 rst SHALL clear button registers, pending move, act_pend, act_flag, bomb register, revealed, flagged, rev_cnt and bomb_total, and set cursor to (0,0). Resulting outputs: I=L=C=M=B=0, F=1, W=0 (rev_cnt=0, bomb_total=0 compares 0 != 64).
REQ-026 rst asserted mid-game SHALL abort any pending action immediately, with no partial reveal or flag.

Configuration
REQ-027 With BUSCAMINAS_ADJ_COUNT_EN defined, adj_count SHALL be the registered count of bombs among the in-bounds neighbours of the cursor, updated the cycle after a cursor change or init.
REQ-028 Without BUSCAMINAS_ADJ_COUNT_EN, adj_count SHALL be tied to 4'd0 and no neighbour logic SHALL be synthesised.

Verification
REQ-029 bomb_map=64'h1, start while idle, then btn_right pulse and a movement strobe -> I pulses 1 cycle, cursor=(1,0), F=1, B=0.
REQ-030 Cursor at (0,0), btn_up then movement; cursor at (7,7), btn_down then movement -> cursor unchanged in both cases.
REQ-031 bomb_map=64'h1, cursor (0,0), sel, then mmm_bomb -> M=1, C=0, B=1 before the strobe; revealed[0]=1 after.
REQ-032 Cursor (1,0), flag, mmm_put_flag, put_flag -> F=1, flagged[1]=1, M=0; repeating the sequence gives flagged[1]=0.
REQ-033 bomb_map=~64'h1, reveal cell 1 -> rev_cnt=1, W=1. With BUSCAMINAS_ADJ_COUNT_EN, cursor (0,0) -> adj_count=3.
REQ-034 rst asserted while act_pend=1 with an mmm_bomb strobe present -> revealed=0, M=0, cursor=(0,0).
